// File: rtl/mem_wait_ctrl.sv
// mem_wait_ctrl: unified instruction/data memory behind a fixed wait-state access controller.
// Define MEM_PARITY_EN to add per-word even parity storage with par_inject/par_err ports.
module mem_wait_ctrl #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 4096,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
`ifdef MEM_PARITY_EN
    input  logic              par_inject,
    output logic              par_err,
`endif
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              addr_err,
    output logic              busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef MEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_r;
    logic [3:0]        cnt_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [MEM_W-1:0]  mem_r [DEPTH];

    logic              in_range_s;
    logic              access_s;
    logic              wr_en_s;
    logic [IDX_W-1:0]  idx_s;
    logic [MEM_W-1:0]  rd_word_s;
    logic [MEM_W-1:0]  wr_word_s;
    logic [DATA_W-1:0] rd_data_s;

`ifdef MEM_PARITY_EN
    logic              inject_r;
    logic              par_bad_s;

    function automatic logic even_parity(input logic [DATA_W-1:0] data);
        return ^data;
    endfunction

    assign wr_word_s = {even_parity(wdata_r) ^ inject_r, wdata_r};
    assign par_bad_s = (rd_word_s[DATA_W] != even_parity(rd_word_s[DATA_W-1:0]));
`else
    assign wr_word_s = wdata_r;
`endif

    // Out-of-range addresses never touch the array: reads yield zero, writes are dropped.
    assign in_range_s = (32'(addr_r) < 32'(DEPTH));
    assign idx_s      = addr_r[IDX_W-1:0];
    assign access_s   = (state_r == ST_WAIT) && (cnt_r == 4'd0);
    assign wr_en_s    = access_s && we_r && in_range_s;
    assign rd_word_s  = mem_r[idx_s];
    assign rd_data_s  = in_range_s ? rd_word_s[DATA_W-1:0] : {DATA_W{1'b0}};

    // Array write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[idx_s] <= wr_word_s;
        end
    end

    // Request/wait/response sequencer with registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            we_r      <= 1'b0;
            addr_r    <= {ADDR_W{1'b0}};
            wdata_r   <= {DATA_W{1'b0}};
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= {DATA_W{1'b0}};
            addr_err  <= 1'b0;
            busy      <= 1'b0;
`ifdef MEM_PARITY_EN
            inject_r  <= 1'b0;
            par_err   <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            addr_err  <= 1'b0;
`ifdef MEM_PARITY_EN
            par_err   <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_r      <= req_we;
                        addr_r    <= req_addr;
                        wdata_r   <= req_wdata;
`ifdef MEM_PARITY_EN
                        inject_r  <= par_inject;
`endif
                        cnt_r     <= 4'(WAIT_CYC);
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state_r   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        rsp_valid <= 1'b1;
                        addr_err  <= ~in_range_s;
                        rsp_rdata <= we_r ? wdata_r : rd_data_s;
`ifdef MEM_PARITY_EN
                        par_err   <= ~we_r & in_range_s & par_bad_s;
`endif
                        state_r   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    cnt_r     <= 4'd0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// Scoreboard bench for mem_wait_ctrl: randomized traffic against a word-level memory model,
// plus a WAIT_CYC=0 instance for the zero-wait timing corner.
module tb_mem_wait_ctrl;

    localparam int WC  = 2;
    localparam int DEP = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // main instance (WAIT_CYC=2, DEPTH=256)
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [11:0] req_addr = 12'h000;
    logic [15:0] req_wdata = 16'h0000;
    logic        req_ready, rsp_valid, addr_err, busy;
    logic [15:0] rsp_rdata;
    logic        par_inject = 1'b0;
`ifdef MEM_PARITY_EN
    logic        par_err;
`endif

    // zero-wait instance
    logic        z_valid = 1'b0, z_we = 1'b0;
    logic [11:0] z_addr = 12'h000;
    logic [15:0] z_wdata = 16'h0000;
    logic        z_ready, z_rsp_valid, z_addr_err, z_busy;
    logic [15:0] z_rsp_rdata;
`ifdef MEM_PARITY_EN
    logic        z_par_err;
`endif

    mem_wait_ctrl #(.ADDR_W(12), .DATA_W(16), .DEPTH(DEP), .WAIT_CYC(WC)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef MEM_PARITY_EN
        .par_inject(par_inject), .par_err(par_err),
`endif
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .addr_err(addr_err), .busy(busy)
    );

    mem_wait_ctrl #(.ADDR_W(12), .DATA_W(16), .DEPTH(4096), .WAIT_CYC(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(z_valid), .req_we(z_we),
        .req_addr(z_addr), .req_wdata(z_wdata),
`ifdef MEM_PARITY_EN
        .par_inject(1'b0), .par_err(z_par_err),
`endif
        .req_ready(z_ready), .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata),
        .addr_err(z_addr_err), .busy(z_busy)
    );

    typedef struct {
        logic [15:0] data;
        logic        chk_data;
        logic        err;
        logic        perr;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [15:0] ref_mem [int];
    logic        ref_bad [int];
    int          n_pass  = 0;
    int          n_total = 0;
    int          last_acc = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    // Issue one request, wait for acceptance, and record its expected response.
    task automatic issue(input logic we, input logic [11:0] addr, input logic [15:0] wdata,
                         input logic inj);
        exp_t e;
        int   n;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        par_inject = inj;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        last_acc = cyc + 1;
        e.due    = last_acc + WC + 1;
        e.err    = (int'(addr) >= DEP);
        e.perr   = 1'b0;
        if (we) begin
            e.data = wdata;
            e.chk_data = 1'b1;
            if (!e.err) begin
                ref_mem[int'(addr)] = wdata;
                ref_bad[int'(addr)] = inj;
            end
        end else if (e.err) begin
            e.data = 16'h0000;
            e.chk_data = 1'b1;
        end else if (ref_mem.exists(int'(addr))) begin
            e.data = ref_mem[int'(addr)];
            e.chk_data = 1'b1;
            e.perr = ref_bad[int'(addr)];
        end else begin
            e.data = 16'h0000;
            e.chk_data = 1'b0;
        end
        sb_q.push_back(e);
        @(negedge clk);
        check("busy_after_accept", 32'(busy), 32'd1);
        check("ready_after_accept", 32'(req_ready), 32'd0);
        // scramble request inputs: they must be ignored until IDLE
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_addr   = 12'($urandom);
        req_wdata  = 16'($urandom);
        par_inject = 1'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    // Response monitor: every rsp_valid pops exactly one expectation.
    always @(negedge clk) begin
        if (rsp_valid) begin
            check("rsp_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check("rsp_cycle", 32'(cyc), 32'(mon_e.due));
                check("addr_err", 32'(addr_err), 32'(mon_e.err));
                if (mon_e.chk_data) check("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.data));
`ifdef MEM_PARITY_EN
                if (mon_e.chk_data) check("par_err", 32'(par_err), 32'(mon_e.perr));
`endif
            end
        end
    end

    int          z_acc [2];
    int          z_rcyc [2];
    logic [15:0] z_rdat [2];
    int          acc_n, rsp_n, pend, acc1;
    logic        rnd_we;
    logic [11:0] rnd_addr;

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_addr_err", 32'(addr_err), 32'd0);
        check("rst_z_ready", 32'(z_ready), 32'd1);

        // write/read round trip with back-to-back issue
        issue(1'b1, 12'h005, 16'h1ABC, 1'b0);
        acc1 = last_acc;
        issue(1'b0, 12'h005, 16'h0000, 1'b0);
        check("issue_gap", 32'(last_acc - acc1), 32'(WC + 3));
        drain();

        // out-of-range write must not alias onto word 0
        issue(1'b1, 12'h000, 16'h0123, 1'b0);
        issue(1'b1, 12'h100, 16'hFFFF, 1'b0);
        issue(1'b0, 12'h100, 16'h0000, 1'b0);
        issue(1'b0, 12'h000, 16'h0000, 1'b0);
        drain();

        // reset during WAIT of a write aborts it
        issue(1'b1, 12'h010, 16'h1111, 1'b0);
        drain();
        @(negedge clk);
        check("ready_before_abort", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h010; req_wdata = 16'h2222;
        @(negedge clk);
        req_valid = 1'b0;
        check("busy_before_abort", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_rsp_rdata", 32'(rsp_rdata), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(1'b0, 12'h010, 16'h0000, 1'b0);
        drain();

`ifdef MEM_PARITY_EN
        issue(1'b1, 12'h020, 16'h0001, 1'b1);
        issue(1'b0, 12'h020, 16'h0000, 1'b0);
        issue(1'b1, 12'h020, 16'h0001, 1'b0);
        issue(1'b0, 12'h020, 16'h0000, 1'b0);
        drain();
`endif

        // randomized traffic, mostly in range, some beyond DEPTH
        for (int i = 0; i < 40; i++) begin
            rnd_we = 1'($urandom);
            if ($urandom_range(0, 3) == 0) rnd_addr = 12'($urandom_range(DEP, 4095));
            else rnd_addr = 12'($urandom_range(0, 15));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(rnd_we, rnd_addr, 16'($urandom), 1'b0);
        end
        drain();

        // zero-wait instance: write then read held back-to-back
        @(negedge clk);
        z_valid = 1'b1; z_we = 1'b1; z_addr = 12'h000; z_wdata = 16'h0F0F;
        acc_n = 0; rsp_n = 0; pend = 0;
        for (int k = 0; k < 12; k++) begin
            if (pend == 1) begin
                z_we = 1'b0;
                z_wdata = 16'($urandom);
            end else if (pend == 2) begin
                z_valid = 1'b0;
            end
            pend = 0;
            if (z_rsp_valid && rsp_n < 2) begin
                z_rcyc[rsp_n] = cyc;
                z_rdat[rsp_n] = z_rsp_rdata;
                rsp_n++;
            end
            if (z_valid && z_ready && acc_n < 2) begin
                z_acc[acc_n] = cyc + 1;
                acc_n++;
                pend = acc_n;
            end
            @(negedge clk);
        end
        check("z_accepts", 32'(acc_n), 32'd2);
        check("z_responses", 32'(rsp_n), 32'd2);
        if (acc_n == 2 && rsp_n == 2) begin
            check("z_issue_gap", 32'(z_acc[1] - z_acc[0]), 32'd3);
            check("z_latency_wr", 32'(z_rcyc[0] - z_acc[0]), 32'd1);
            check("z_latency_rd", 32'(z_rcyc[1] - z_acc[1]), 32'd1);
            check("z_wr_echo", 32'(z_rdat[0]), 32'h0F0F);
            check("z_rd_data", 32'(z_rdat[1]), 32'h0F0F);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
